multicycle_datapath: RTL and testbench
======================================

// Module: multicycle_datapath
// PURPOSE
//  Parametrised multi-cycle MIPS-subset core. Successor to the single-cycle datapath.
//  One FSM sequences fetch/decode/execute/mem/writeback over a shared ALU.
//  Instruction and data accesses use one external memory port with a req/ack handshake,
//  so wait-state memories are supported. Adds halt, a retired-instruction counter and a
//  debug register read port.
// PARAMETERS
//  ADDR_W      32        width of PC and memory byte address (>=8)
//  RESET_PC    0         PC value loaded on reset (word aligned)
//  HALT_OP     6'h3F     opcode that stops the core
// PORTS
//  Clk         in   1       clock, all state updates on rising edge
//  Rst         in   1       synchronous reset, active high
//  mem_req     out  1       memory request, held until acked
//  mem_we      out  1       1 = write (sw), 0 = read (fetch/lw)
//  mem_addr    out  ADDR_W  byte address, word aligned
//  mem_wdata   out  32      store data (valid when mem_we=1)
//  mem_rdata   in   32      read data, sampled on ack cycle
//  mem_ack     in   1       transaction complete this cycle
//  pc          out  ADDR_W  current PC
//  state       out  3       FSM state encoding (see below)
//  halted      out  1       1 once HALT_OP retired
//  retired     out  32      count of retired instructions
//  dbg_raddr   in   5       debug register index
//  dbg_rdata   out  32      combinational read of reg[dbg_raddr]; reg0 reads 0
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, halted=0, retired=0, all 32 regs=0.
//    Reset overrides everything, including an in-flight request. mem_req is 0 on the first
//    cycle after Rst drops; the request is issued one cycle later.
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 HALT=5.
//  Handshake: address, we and wdata stay stable while mem_req=1. A transaction completes on
//    the edge where mem_req=1 and mem_ack=1. mem_req drops the next cycle. mem_ack is
//    ignored while mem_req=0. Zero-wait memory gives 1 cycle per access.
//  FETCH: issue read at pc. On ack: IR<=mem_rdata, pc<=pc+4 -> DECODE.
//  DECODE: A<=reg[rs], B<=reg[rt], T<=pc+(sext(imm)<<2).
//    Next state: HALT_OP -> HALT (retired+1). j -> pc<={pc[ADDR_W-1:28],target,2'b00},
//    retire -> FETCH. beq -> EXEC. Other opcodes -> EXEC.
//  EXEC: ALU result -> R, per opcode:
//    R-type funct 20 add, 22 sub, 24 and, 25 or, 2A slt (signed).
//    lw 23 / sw 2B: R=A+sext(imm), -> MEM.
//    addi 08: R=A+sext(imm), -> WB.
//    beq 04: if A==B then pc<=T; retire -> FETCH.
//    R-type -> WB.
//  MEM: lw issues read at R; on ack MDR<=mem_rdata -> WB. sw issues write of B at R;
//    on ack retire -> FETCH.
//  WB: R-type rd<=R; addi rt<=R; lw rt<=MDR. Writes to reg0 discarded. Retire -> FETCH.
//  Unknown opcode or funct: no register/memory effect; retired as NOP via EXEC -> FETCH.
//  Arithmetic: 32-bit wrap, no overflow trap. Addresses use low ADDR_W bits. PC wraps at 2^ADDR_W.
//  Cycle counts (zero-wait): j/halt 2, beq 3, R/addi 4, sw 4, lw 5; each wait cycle adds 1.
//  HALT: mem_req=0; pc, regs and retired frozen until Rst.
//  retired increments exactly once per instruction, on its final-state exit edge.
//  dbg_rdata reflects a write in the same cycle only after the edge (no bypass).
// TESTING
//  1. Rst 2 cycles, zero-wait mem: mem_req=0 first cycle, then read at addr 0, pc=0, retired=0.
//  2. addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; halt -> reg3=2, retired=4, halted=1, 14 cycles.
//  3. sw $1,8($0); lw $4,8($0) with ack delayed 3 cycles per access -> mem[8]=5, reg4=5, req stable.
//  4. beq taken and not-taken (A==B, A!=B), imm=-1 -> pc loops/advances; slt -1<1 gives 1.
//  5. addi $0,$0,7 then dbg_raddr=0 -> dbg_rdata=0; j 0x40 -> next fetch addr 0x100.
//  6. Rst asserted while mem_req=1 awaiting ack -> req drops, pc=RESET_PC, late ack ignored.

Source files
------------

// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-subset core: one FSM sequences fetch/decode/exec/mem/wb over a shared ALU
// and a single req/ack memory port, with halt, retired-instruction counter and debug read port.
module multicycle_datapath #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3F
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic [31:0]       retired,
    input  logic [4:0]        dbg_raddr,
    output logic [31:0]       dbg_rdata
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic [31:0] alu(input logic r_type, input logic [5:0] fn,
                                        input logic signed [31:0] a,
                                        input logic signed [31:0] b,
                                        input logic [31:0] imm);
        logic [31:0] y;
        y = a + imm;
        if (r_type) begin
            case (fn)
                FN_ADD:  y = a + b;
                FN_SUB:  y = a - b;
                FN_AND:  y = a & b;
                FN_OR:   y = a | b;
                FN_SLT:  y = {31'd0, (a < b)};
                default: y = '0;
            endcase
        end
        return y;
    endfunction

    state_t st, st_nxt;
    logic   init;
    logic   retire;
    logic   xfer;

    logic [31:0]        ir;
    logic signed [31:0] a_q;
    logic signed [31:0] b_q;
    logic [ADDR_W-1:0]  t_q;
    logic [31:0]        r_q;
    logic [31:0]        mdr;
    logic [31:0]        regs [32];

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] simm;
    logic        is_halt, is_j, is_beq, is_addi, is_lw, is_sw, is_r, fn_ok;

    logic [31:0]        pc32;
    logic [31:0]        jaddr32;
    logic signed [31:0] boff32;
    logic [4:0]         wr_idx;
    logic [31:0]        wb_data;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign simm  = sext16(ir[15:0]);

    // Halt opcode takes priority over any opcode it may alias.
    assign is_halt = (op == HALT_OP);
    assign is_j    = !is_halt && (op == OP_J);
    assign is_beq  = !is_halt && (op == OP_BEQ);
    assign is_addi = !is_halt && (op == OP_ADDI);
    assign is_lw   = !is_halt && (op == OP_LW);
    assign is_sw   = !is_halt && (op == OP_SW);
    assign is_r    = !is_halt && (op == OP_RTYPE);
    assign fn_ok   = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);

    assign pc32    = 32'(pc);
    assign jaddr32 = (pc32 & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
    assign boff32  = {{14{ir[15]}}, ir[15:0], 2'b00};

    assign wr_idx  = is_r ? rd : rt;
    assign wb_data = is_lw ? mdr : r_q;

    assign state     = st;
    assign halted    = (st == HALT);
    assign mem_wdata = b_q;
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs[dbg_raddr];
    assign xfer      = mem_req && mem_ack;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            st   <= FETCH;
            init <= 1'b1;
        end else begin
            st   <= st_nxt;
            init <= 1'b0;
        end
    end

    // The request is a decode of the state, so it stays asserted until the acking edge.
    always_comb begin
        st_nxt   = st;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_addr = pc;
        retire   = 1'b0;
        case (st)
            FETCH: begin
                mem_req = !init;
                if (!init && mem_ack) st_nxt = DECODE;
            end
            DECODE: begin
                if (is_halt) begin
                    st_nxt = HALT;
                    retire = 1'b1;
                end else if (is_j) begin
                    st_nxt = FETCH;
                    retire = 1'b1;
                end else begin
                    st_nxt = EXEC;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    st_nxt = MEM;
                end else if (is_addi || (is_r && fn_ok)) begin
                    st_nxt = WB;
                end else begin
                    st_nxt = FETCH;
                    retire = 1'b1;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_sw;
                mem_addr = ADDR_W'(r_q);
                if (mem_ack) begin
                    if (is_sw) begin
                        st_nxt = FETCH;
                        retire = 1'b1;
                    end else begin
                        st_nxt = WB;
                    end
                end
            end
            WB: begin
                st_nxt = FETCH;
                retire = 1'b1;
            end
            HALT:    st_nxt = HALT;
            default: st_nxt = FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc      <= RESET_PC;
            retired <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            if (st == FETCH && xfer) pc <= pc + ADDR_W'(4);
            if (st == DECODE && is_j) pc <= ADDR_W'(jaddr32);
            if (st == EXEC && is_beq && a_q == b_q) pc <= t_q;
            if (retire) retired <= retired + 32'd1;
            if (st == WB && wr_idx != 5'd0) regs[wr_idx] <= wb_data;
        end
    end

    // Datapath holding registers; their contents only matter once the FSM consumes them.
    always_ff @(posedge Clk) begin
        if (st == FETCH && xfer) ir <= mem_rdata;
        if (st == DECODE) begin
            a_q <= regs[rs];
            b_q <= regs[rt];
            t_q <= pc + ADDR_W'(boff32);
        end
        if (st == EXEC) r_q <= alu(is_r, funct, a_q, b_q, simm);
        if (st == MEM && xfer) mdr <= mem_rdata;
    end

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath with a wait-state memory responder.
module tb_multicycle_datapath;

    logic        Clk;
    logic        Rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] pc;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] retired;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;

    multicycle_datapath dut (
        .Clk(Clk), .Rst(Rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .pc(pc), .state(state), .halted(halted), .retired(retired),
        .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic [31:0] mem [0:255];
    int          ack_delay;
    logic        mem_en;
    int          waitcnt;
    logic        in_txn;
    logic [31:0] s_addr;
    logic        s_we;
    logic [31:0] s_wdata;
    int          stab_err;
    logic [31:0] last_addr;

    int n_chk;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Memory responder: decides ack/rdata at each falling edge.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        waitcnt   = 0;
        in_txn    = 1'b0;
        stab_err  = 0;
        last_addr = '0;
        forever begin
            @(negedge Clk);
            if (!mem_en) begin
                waitcnt = 0;
                in_txn  = 1'b0;
            end else if (mem_req) begin
                if (in_txn) begin
                    if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata)
                        stab_err++;
                end else begin
                    s_addr  = mem_addr;
                    s_we    = mem_we;
                    s_wdata = mem_wdata;
                    in_txn  = 1'b1;
                end
                if (waitcnt < ack_delay) begin
                    mem_ack = 1'b0;
                    waitcnt++;
                end else begin
                    mem_ack   = 1'b1;
                    waitcnt   = 0;
                    in_txn    = 1'b0;
                    last_addr = mem_addr;
                    if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[9:2]];
                end
            end else begin
                mem_ack = 1'b0;
                waitcnt = 0;
                in_txn  = 1'b0;
            end
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    localparam logic [31:0] HALT_I = {6'h3F, 26'd0};

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic rd_reg(input int idx, output logic [31:0] v);
        dbg_raddr = 5'(idx);
        #1;
        v = dbg_rdata;
    endtask

    task automatic run_to_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 500) begin
            step(1);
            cyc++;
        end
    endtask

    logic [31:0] v;
    int          cyc;

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        Rst       = 1'b1;
        dbg_raddr = '0;
        mem_en    = 1'b1;
        ack_delay = 0;

        // Reset, then add/addi program
        clear_mem();
        mem[0] = enc_i(6'h08, 1, 0, 5);
        mem[1] = enc_i(6'h08, 2, 0, -3);
        mem[2] = enc_r(6'h20, 3, 1, 2);
        mem[3] = HALT_I;
        do_reset();
        #1;
        check("rst_req", mem_req, 0);
        check("rst_pc", pc, 0);
        check("rst_retired", retired, 0);
        check("rst_state", state, 0);
        check("rst_halted", halted, 0);
        step(1);
        check("first_req", mem_req, 1);
        check("first_addr", mem_addr, 32'h0);
        check("first_we", mem_we, 0);
        run_to_halt(cyc);
        check("t2_cycles", cyc, 14);
        check("t2_halted", halted, 1);
        check("t2_state", state, 5);
        check("t2_retired", retired, 4);
        check("t2_pc", pc, 32'h10);
        rd_reg(1, v); check("t2_r1", v, 32'd5);
        rd_reg(2, v); check("t2_r2", v, 32'hFFFF_FFFD);
        rd_reg(3, v); check("t2_r3", v, 32'd2);
        step(3);
        check("t2_frozen_req", mem_req, 0);
        check("t2_frozen_ret", retired, 4);
        check("t2_frozen_pc", pc, 32'h10);

        // sw/lw with three wait cycles per access
        clear_mem();
        mem[0] = enc_i(6'h08, 1, 0, 5);
        mem[1] = enc_j(4);
        mem[4] = enc_i(6'h2B, 1, 0, 8);
        mem[5] = enc_i(6'h23, 4, 0, 8);
        mem[6] = HALT_I;
        ack_delay = 3;
        stab_err  = 0;
        do_reset();
        #1;
        rd_reg(3, v); check("t3_rst_r3", v, 32'd0);
        step(1);
        run_to_halt(cyc);
        check("t3_cycles", cyc, 38);
        check("t3_mem8", mem[2], 32'd5);
        rd_reg(4, v); check("t3_r4", v, 32'd5);
        check("t3_retired", retired, 5);
        check("t3_stable", stab_err, 0);

        // slt and beq not-taken / taken
        clear_mem();
        mem[0] = enc_i(6'h08, 1, 0, -1);
        mem[1] = enc_i(6'h08, 2, 0, 1);
        mem[2] = enc_r(6'h2A, 5, 1, 2);
        mem[3] = enc_i(6'h04, 2, 1, -1);
        mem[4] = enc_i(6'h04, 1, 1, -1);
        ack_delay = 0;
        do_reset();
        step(1);
        step(15);
        check("t4_nt_pc", pc, 32'h10);
        check("t4_nt_ret", retired, 4);
        check("t4_nt_state", state, 0);
        rd_reg(5, v); check("t4_slt", v, 32'd1);
        rd_reg(1, v); check("t4_r1", v, 32'hFFFF_FFFF);
        step(1);
        check("t4_fetch_pc", pc, 32'h14);
        step(2);
        check("t4_tk_pc", pc, 32'h10);
        check("t4_tk_ret", retired, 5);
        step(3);
        check("t4_loop_pc", pc, 32'h10);
        check("t4_loop_ret", retired, 6);

        // reg0 write discarded, unknown opcode as NOP, jump
        clear_mem();
        mem[0]  = enc_i(6'h08, 0, 0, 7);
        mem[1]  = enc_i(6'h3E, 1, 0, 9);
        mem[2]  = enc_j(32'h40);
        mem[64] = HALT_I;
        do_reset();
        step(1);
        run_to_halt(cyc);
        check("t5_cycles", cyc, 11);
        rd_reg(0, v); check("t5_r0", v, 32'd0);
        rd_reg(1, v); check("t5_r1_nop", v, 32'd0);
        check("t5_jaddr", last_addr, 32'h100);
        check("t5_pc", pc, 32'h104);
        check("t5_retired", retired, 4);

        // Reset in the middle of a pending fetch, then a stray ack
        do_reset();
        step(1);
        step(4);
        ack_delay = 100;
        step(2);
        check("t6_pend_req", mem_req, 1);
        check("t6_pend_pc", pc, 32'h4);
        @(negedge Clk);
        Rst     = 1'b1;
        mem_en  = 1'b0;
        mem_ack = 1'b0;
        step(1);
        check("t6_rst_req", mem_req, 0);
        check("t6_rst_pc", pc, 32'h0);
        check("t6_rst_ret", retired, 0);
        @(negedge Clk);
        Rst     = 1'b0;
        mem_ack = 1'b1;
        step(1);
        mem_ack = 1'b0;
        check("t6_late_pc", pc, 32'h0);
        check("t6_late_state", state, 0);
        check("t6_req_again", mem_req, 1);
        ack_delay = 0;
        mem_en    = 1'b1;
        run_to_halt(cyc);
        check("t6_cycles", cyc, 11);
        check("t6_retired", retired, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
